// File: rtl/nonlinear_sequencer.sv
// Job-level controller for the nonlinear block: accepts a job descriptor,
// optionally streams LUT entries into the sig_tanh LUT, runs the selected
// engine until finished_activation (or timeout/abort) and reports completion.
module nonlinear_sequencer #(
   parameter int unsigned LUT_ADDR                           = 8,
   parameter int unsigned LUT_DATA_WIDTH                     = 16,
   parameter int unsigned NUMBER_OF_NONLINEAR_FUNCTIONS_BITS = 3,
   parameter int unsigned TIMEOUT_BITS                       = 24
) (
   input  logic                                          clk,
   input  logic                                          reset,
   input  logic                                          job_valid,
   output logic                                          job_ready,
   input  logic                                          job_mode,
   input  logic [NUMBER_OF_NONLINEAR_FUNCTIONS_BITS-1:0] job_type_nl,
   input  logic                                          job_load_lut,
   input  logic [LUT_ADDR:0]                             job_lut_len,
   input  logic [31:0]                                   job_act_cycles,
   input  logic [TIMEOUT_BITS-1:0]                       timeout_limit,
   input  logic                                          abort,
   input  logic                                          lut_valid,
   input  logic [LUT_DATA_WIDTH-1:0]                     lut_data,
   output logic                                          lut_ready,
   output logic                                          wr_en_ext_lut,
   output logic [LUT_ADDR-1:0]                           wr_addr_ext_lut,
   output logic [LUT_DATA_WIDTH-1:0]                     wr_data_ext_lut,
   output logic                                          enable_nonlinear_block,
   output logic                                          enable_pooling,
   output logic                                          enable_sig_tanh,
   output logic [NUMBER_OF_NONLINEAR_FUNCTIONS_BITS-1:0] type_nonlinear_function,
   output logic [31:0]                                   NUMBER_OF_ACTIVATION_CYCLES,
   input  logic                                          finished_activation,
   output logic                                          busy,
   output logic                                          job_done,
   output logic                                          job_error
);

   localparam int unsigned LenW  = LUT_ADDR + 1;
   localparam int unsigned TypeW = NUMBER_OF_NONLINEAR_FUNCTIONS_BITS;

   typedef enum logic [2:0] {StIdle, StLutLoad, StStart, StRun, StDone} state_e;

   state_e                      state_q, state_d;
   logic                        mode_q, mode_d;
   logic [TypeW-1:0]            type_q, type_d;
   logic [31:0]                 act_q, act_d;
   logic [TIMEOUT_BITS-1:0]     limit_q, limit_d;
   logic [LenW-1:0]             len_q, len_d;
   logic [LenW-1:0]             beat_q, beat_d;
   logic [TIMEOUT_BITS-1:0]     run_cnt_q, run_cnt_d;
   logic                        en_nl_q, en_nl_d;
   logic                        en_pool_q, en_pool_d;
   logic                        en_sig_q, en_sig_d;
   logic                        lut_ready_q, lut_ready_d;
   logic                        wr_en_q, wr_en_d;
   logic [LUT_ADDR-1:0]         wr_addr_q, wr_addr_d;
   logic [LUT_DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
   logic                        done_q, done_d;
   logic                        error_q, error_d;
   logic                        busy_q, busy_d;
   logic                        accept;

   assign job_ready = (state_q == StIdle);
   // An abort seen in IDLE suppresses the handshake for that cycle.
   assign accept    = job_ready && job_valid && !abort;

   // Next-state and registered-output decode.
   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      type_d    = type_q;
      act_d     = act_q;
      limit_d   = limit_q;
      len_d     = len_q;
      beat_d    = beat_q;
      run_cnt_d = run_cnt_q;
      en_nl_d   = en_nl_q;
      en_pool_d = en_pool_q;
      en_sig_d  = en_sig_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      done_d    = 1'b0;
      error_d   = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               mode_d  = job_mode;
               type_d  = job_type_nl;
               act_d   = job_act_cycles;
               limit_d = timeout_limit;
               len_d   = job_lut_len;
               beat_d  = '0;
               state_d = (job_load_lut && job_lut_len != '0) ? StLutLoad : StStart;
            end
         end
         StLutLoad: begin
            if (lut_valid && lut_ready_q) begin
               wr_en_d   = 1'b1;
               wr_addr_d = beat_q[LUT_ADDR-1:0];
               wr_data_d = lut_data;
               beat_d    = beat_q + LenW'(1);
               if (beat_q == len_q - LenW'(1)) state_d = StStart;
            end
         end
         StStart: begin
            en_nl_d   = 1'b1;
            en_pool_d = !mode_q;
            en_sig_d  = mode_q;
            run_cnt_d = '0;
            state_d   = StRun;
         end
         StRun: begin
            run_cnt_d = run_cnt_q + TIMEOUT_BITS'(1);
            // Completion takes priority over a coincident timeout.
            if (finished_activation) begin
               en_nl_d = 1'b0;
               state_d = StDone;
            end else if (limit_q != '0 && run_cnt_q == limit_q - TIMEOUT_BITS'(1)) begin
               error_d   = 1'b1;
               en_nl_d   = 1'b0;
               en_pool_d = 1'b0;
               en_sig_d  = 1'b0;
               state_d   = StIdle;
            end
         end
         StDone: begin
            done_d    = 1'b1;
            en_nl_d   = 1'b0;
            en_pool_d = 1'b0;
            en_sig_d  = 1'b0;
            state_d   = StIdle;
         end
         default: state_d = StIdle;
      endcase

      // Abort drops everything, including a beat accepted this cycle.
      if (abort && state_q != StIdle) begin
         state_d   = StIdle;
         en_nl_d   = 1'b0;
         en_pool_d = 1'b0;
         en_sig_d  = 1'b0;
         wr_en_d   = 1'b0;
         done_d    = 1'b0;
         error_d   = 1'b0;
      end

      lut_ready_d = (state_d == StLutLoad);
      busy_d      = (state_d != StIdle);
   end

   // State and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         mode_q      <= 1'b0;
         type_q      <= '0;
         act_q       <= '0;
         limit_q     <= '0;
         len_q       <= '0;
         beat_q      <= '0;
         run_cnt_q   <= '0;
         en_nl_q     <= 1'b0;
         en_pool_q   <= 1'b0;
         en_sig_q    <= 1'b0;
         lut_ready_q <= 1'b0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         type_q      <= type_d;
         act_q       <= act_d;
         limit_q     <= limit_d;
         len_q       <= len_d;
         beat_q      <= beat_d;
         run_cnt_q   <= run_cnt_d;
         en_nl_q     <= en_nl_d;
         en_pool_q   <= en_pool_d;
         en_sig_q    <= en_sig_d;
         lut_ready_q <= lut_ready_d;
         wr_en_q     <= wr_en_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         done_q      <= done_d;
         error_q     <= error_d;
         busy_q      <= busy_d;
      end
   end

   assign lut_ready                   = lut_ready_q;
   assign wr_en_ext_lut               = wr_en_q;
   assign wr_addr_ext_lut             = wr_addr_q;
   assign wr_data_ext_lut             = wr_data_q;
   assign enable_nonlinear_block      = en_nl_q;
   assign enable_pooling              = en_pool_q;
   assign enable_sig_tanh             = en_sig_q;
   assign type_nonlinear_function     = type_q;
   assign NUMBER_OF_ACTIVATION_CYCLES = act_q;
   assign busy                        = busy_q;
   assign job_done                    = done_q;
   assign job_error                   = error_q;

endmodule

// File: tb/tb_nonlinear_sequencer.sv
// Self-checking bench for nonlinear_sequencer: scenario tasks plus randomized
// jobs checked against event times derived from the job-level rules.
module tb_nonlinear_sequencer;

   localparam int LA  = 8;
   localparam int DW  = 16;
   localparam int TW  = 3;
   localparam int TOB = 24;

   logic           clk, reset;
   logic           job_valid, job_ready, job_mode, job_load_lut;
   logic [TW-1:0]  job_type_nl;
   logic [LA:0]    job_lut_len;
   logic [31:0]    job_act_cycles;
   logic [TOB-1:0] timeout_limit;
   logic           abort, lut_valid, lut_ready, wr_en_ext_lut;
   logic [DW-1:0]  lut_data, wr_data_ext_lut;
   logic [LA-1:0]  wr_addr_ext_lut;
   logic           enable_nonlinear_block, enable_pooling, enable_sig_tanh;
   logic [TW-1:0]  type_nonlinear_function;
   logic [31:0]    NUMBER_OF_ACTIVATION_CYCLES;
   logic           finished_activation, busy, job_done, job_error;

   nonlinear_sequencer #(
      .LUT_ADDR(LA), .LUT_DATA_WIDTH(DW),
      .NUMBER_OF_NONLINEAR_FUNCTIONS_BITS(TW), .TIMEOUT_BITS(TOB)
   ) dut (
      .clk(clk), .reset(reset), .job_valid(job_valid), .job_ready(job_ready),
      .job_mode(job_mode), .job_type_nl(job_type_nl), .job_load_lut(job_load_lut),
      .job_lut_len(job_lut_len), .job_act_cycles(job_act_cycles),
      .timeout_limit(timeout_limit), .abort(abort), .lut_valid(lut_valid),
      .lut_data(lut_data), .lut_ready(lut_ready), .wr_en_ext_lut(wr_en_ext_lut),
      .wr_addr_ext_lut(wr_addr_ext_lut), .wr_data_ext_lut(wr_data_ext_lut),
      .enable_nonlinear_block(enable_nonlinear_block), .enable_pooling(enable_pooling),
      .enable_sig_tanh(enable_sig_tanh), .type_nonlinear_function(type_nonlinear_function),
      .NUMBER_OF_ACTIVATION_CYCLES(NUMBER_OF_ACTIVATION_CYCLES),
      .finished_activation(finished_activation), .busy(busy), .job_done(job_done),
      .job_error(job_error)
   );

   int n_vec = 0;
   int n_bad = 0;

   // Monitor state, sampled 1 time unit after each rising edge.
   int            cyc = 0;
   int            n_done, n_err, t_done, t_err, t_rise, t_fall, both_hi;
   logic          en_prev, seen_pool, seen_sig;
   logic [LA-1:0] w_addr[$];
   logic [DW-1:0] w_data[$];
   logic [DW-1:0] lut_src[256];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired at cycle %0d, required completion", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      en_prev = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (wr_en_ext_lut) begin
            w_addr.push_back(wr_addr_ext_lut);
            w_data.push_back(wr_data_ext_lut);
         end
         if (job_done) begin n_done++; t_done = cyc; end
         if (job_error) begin n_err++; t_err = cyc; end
         if (enable_nonlinear_block && !en_prev) t_rise = cyc;
         if (!enable_nonlinear_block && en_prev) t_fall = cyc;
         en_prev = enable_nonlinear_block;
         if (enable_pooling && enable_sig_tanh) both_hi++;
         if (enable_nonlinear_block) begin
            seen_pool = seen_pool | enable_pooling;
            seen_sig  = seen_sig | enable_sig_tanh;
         end
      end
   end

   task automatic clr_mon();
      n_done = 0; n_err = 0; both_hi = 0;
      t_done = -1; t_err = -1; t_rise = -1; t_fall = -1;
      seen_pool = 1'b0; seen_sig = 1'b0;
      w_addr.delete(); w_data.delete();
   endtask

   // Stimulus only: present a job, stream LUT beats, pulse finished at RUN cycle fin_at.
   task automatic drive_job(input logic m, input logic [TW-1:0] ty, input logic [31:0] act,
                            input logic ld, input int len, input logic [TOB-1:0] lim,
                            input int fin_at, input int gap_pct, input int gap_at,
                            output int acc, output int lb, output int r);
      int beats, guard, idle;
      @(negedge clk);
      job_valid = 1'b1; job_mode = m; job_type_nl = ty; job_act_cycles = act;
      job_load_lut = ld; job_lut_len = (LA+1)'(len); timeout_limit = lim;
      acc = cyc;
      lb  = -1;
      @(negedge clk);
      // Scramble the descriptor to prove the DUT latched it.
      job_valid = 1'b0; job_mode = 1'($urandom); job_type_nl = TW'($urandom);
      job_act_cycles = $urandom; timeout_limit = TOB'($urandom);
      job_lut_len = (LA+1)'($urandom);
      if (ld && len != 0) begin
         beats = 0; guard = 0; idle = 0;
         while (beats < len && guard < 3000) begin
            finished_activation = 1'($urandom);
            if (beats == gap_at && idle < 2) begin
               lut_valid = 1'b0; idle++;
            end else if (lut_ready && $urandom_range(99) >= gap_pct) begin
               lut_valid = 1'b1; lut_data = lut_src[beats]; lb = cyc; beats++;
            end else begin
               lut_valid = 1'b0; lut_data = DW'($urandom);
            end
            @(negedge clk);
            guard++;
         end
         lut_valid = 1'b0;
      end
      r = (lb >= 0) ? lb + 2 : acc + 2;
      guard = 0;
      while ((busy || cyc < r) && guard < 500) begin
         if (cyc < r) finished_activation = 1'($urandom);
         else finished_activation = (fin_at >= 0 && cyc == r + fin_at);
         @(negedge clk);
         guard++;
      end
      finished_activation = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_vec++;
      if ({lut_ready, wr_en_ext_lut, wr_addr_ext_lut, wr_data_ext_lut, enable_nonlinear_block,
           enable_pooling, enable_sig_tanh, type_nonlinear_function, NUMBER_OF_ACTIVATION_CYCLES,
           busy, job_done, job_error} !== '0) begin
         n_bad++; $display("FAIL reset_outputs got nonzero outputs, required all 0");
      end
      n_vec++;
      if (job_ready !== 1'b1) begin
         n_bad++; $display("FAIL reset_job_ready got %b want 1", job_ready);
      end
      reset = 1'b0;
      @(negedge clk);
      n_vec++;
      if ({busy, job_ready} !== 2'b01) begin
         n_bad++; $display("FAIL post_reset busy/ready got %b want 01", {busy, job_ready});
      end
   endtask

   task automatic test_pooling();
      int acc, lb, r;
      clr_mon();
      drive_job(1'b0, 3'd2, 32'd100, 1'b0, 0, '0, 10, 0, -1, acc, lb, r);
      n_vec++;
      if (t_rise !== acc + 2) begin
         n_bad++; $display("FAIL pool_enable_time got %0d want %0d", t_rise, acc + 2);
      end
      n_vec++;
      if (t_fall !== acc + 13) begin
         n_bad++; $display("FAIL pool_enable_drop got %0d want %0d", t_fall, acc + 13);
      end
      n_vec++;
      if (t_done !== acc + 14 || n_done !== 1 || n_err !== 0) begin
         n_bad++; $display("FAIL pool_done got t=%0d n=%0d err=%0d want t=%0d n=1 err=0",
                           t_done, n_done, n_err, acc + 14);
      end
      n_vec++;
      if ({seen_pool, seen_sig, both_hi != 0} !== 3'b100) begin
         n_bad++; $display("FAIL pool_selects got %b want 100", {seen_pool, seen_sig, both_hi != 0});
      end
      n_vec++;
      if ({type_nonlinear_function, NUMBER_OF_ACTIVATION_CYCLES} !== {3'd2, 32'd100}) begin
         n_bad++; $display("FAIL pool_latched got %0d/%0d want 2/100",
                           type_nonlinear_function, NUMBER_OF_ACTIVATION_CYCLES);
      end
      n_vec++;
      if ({enable_pooling, busy, job_ready} !== 3'b001) begin
         n_bad++; $display("FAIL pool_idle got %b want 001", {enable_pooling, busy, job_ready});
      end
   endtask

   task automatic test_lut_load();
      int acc, lb, r;
      for (int i = 0; i < 4; i++) lut_src[i] = DW'(16'h0011 + i);
      clr_mon();
      drive_job(1'b1, 3'd5, 32'd37, 1'b1, 4, '0, 3, 0, 2, acc, lb, r);
      n_vec++;
      if (w_addr.size() !== 4) begin
         n_bad++; $display("FAIL lut_write_count got %0d want 4", w_addr.size());
      end
      for (int i = 0; i < 4; i++) begin
         n_vec++;
         if ({w_addr[i], w_data[i]} !== {LA'(i), lut_src[i]}) begin
            n_bad++; $display("FAIL lut_write%0d got %h/%h want %h/%h", i, w_addr[i], w_data[i],
                              LA'(i), lut_src[i]);
         end
      end
      n_vec++;
      if (t_rise !== lb + 2) begin
         n_bad++; $display("FAIL lut_start_time got %0d want %0d", t_rise, lb + 2);
      end
      n_vec++;
      if ({seen_sig, seen_pool, n_done == 1} !== 3'b101) begin
         n_bad++; $display("FAIL lut_sig_done got %b want 101", {seen_sig, seen_pool, n_done == 1});
      end
   endtask

   task automatic test_timeout();
      int acc, lb, r;
      clr_mon();
      drive_job(1'b1, 3'd1, 32'd9, 1'b0, 0, 24'd5, -1, 0, -1, acc, lb, r);
      n_vec++;
      if (t_err !== acc + 7 || n_err !== 1) begin
         n_bad++; $display("FAIL timeout_error got t=%0d n=%0d want t=%0d n=1", t_err, n_err, acc + 7);
      end
      n_vec++;
      if (n_done !== 0 || t_fall !== acc + 7) begin
         n_bad++; $display("FAIL timeout_done_en got done=%0d fall=%0d want 0/%0d",
                           n_done, t_fall, acc + 7);
      end
      n_vec++;
      if ({busy, job_ready, enable_sig_tanh} !== 3'b010) begin
         n_bad++; $display("FAIL timeout_idle got %b want 010", {busy, job_ready, enable_sig_tanh});
      end
   endtask

   task automatic test_race();
      int acc, lb, r;
      clr_mon();
      drive_job(1'b0, 3'd3, 32'd4, 1'b0, 0, 24'd3, 2, 0, -1, acc, lb, r);
      n_vec++;
      if ({n_done, n_err} !== {32'd1, 32'd0} || t_done !== acc + 6) begin
         n_bad++; $display("FAIL race got done=%0d err=%0d t=%0d want 1/0/%0d",
                           n_done, n_err, t_done, acc + 6);
      end
   endtask

   task automatic test_abort();
      int acc, lb, r, beats, guard;
      for (int i = 0; i < 8; i++) lut_src[i] = DW'($urandom);
      clr_mon();
      @(negedge clk);
      job_valid = 1'b1; job_mode = 1'b1; job_load_lut = 1'b1; job_lut_len = 9'd8;
      timeout_limit = '0;
      @(negedge clk);
      job_valid = 1'b0;
      beats = 0; guard = 0;
      while (beats < 2 && guard < 50) begin
         if (lut_ready) begin lut_valid = 1'b1; lut_data = lut_src[beats]; beats++; end
         else lut_valid = 1'b0;
         @(negedge clk);
         guard++;
      end
      abort = 1'b1; lut_valid = 1'b1; lut_data = lut_src[2];
      @(negedge clk);
      abort = 1'b0; lut_valid = 1'b0;
      n_vec++;
      if ({busy, lut_ready, job_ready} !== 3'b001) begin
         n_bad++; $display("FAIL abort_idle got %b want 001", {busy, lut_ready, job_ready});
      end
      repeat (3) @(negedge clk);
      n_vec++;
      if (w_addr.size() !== 2) begin
         n_bad++; $display("FAIL abort_write_count got %0d want 2", w_addr.size());
      end
      for (int i = 0; i < 2; i++) begin
         n_vec++;
         if ({w_addr[i], w_data[i]} !== {LA'(i), lut_src[i]}) begin
            n_bad++; $display("FAIL abort_write%0d got %h/%h want %h/%h", i, w_addr[i], w_data[i],
                              LA'(i), lut_src[i]);
         end
      end
      n_vec++;
      if (n_done !== 0 || n_err !== 0 || t_rise !== -1) begin
         n_bad++; $display("FAIL abort_pulses got done=%0d err=%0d rise=%0d want 0/0/-1",
                           n_done, n_err, t_rise);
      end
      // Abort in IDLE blocks the handshake.
      job_valid = 1'b1; job_load_lut = 1'b0; abort = 1'b1;
      @(negedge clk);
      job_valid = 1'b0; abort = 1'b0;
      n_vec++;
      if (busy !== 1'b0) begin
         n_bad++; $display("FAIL abort_idle_block got busy=%b want 0", busy);
      end
      clr_mon();
      drive_job(1'b0, 3'd4, 32'd8, 1'b0, 0, '0, 0, 0, -1, acc, lb, r);
      n_vec++;
      if (n_done !== 1 || t_done !== acc + 4) begin
         n_bad++; $display("FAIL abort_next_job got n=%0d t=%0d want 1/%0d", n_done, t_done, acc + 4);
      end
   endtask

   task automatic test_async_reset();
      int guard;
      clr_mon();
      @(negedge clk);
      job_valid = 1'b1; job_mode = 1'b1; job_type_nl = 3'd6; job_act_cycles = 32'd55;
      job_load_lut = 1'b0; timeout_limit = '0;
      @(negedge clk);
      job_valid = 1'b0;
      guard = 0;
      while (!enable_nonlinear_block && guard < 20) begin @(negedge clk); guard++; end
      repeat (2) @(negedge clk);
      n_vec++;
      if (enable_nonlinear_block !== 1'b1) begin
         n_bad++; $display("FAIL arst_run got enable=%b want 1", enable_nonlinear_block);
      end
      #2 reset = 1'b1;
      #1;
      n_vec++;
      if ({lut_ready, wr_en_ext_lut, wr_addr_ext_lut, wr_data_ext_lut, enable_nonlinear_block,
           enable_pooling, enable_sig_tanh, type_nonlinear_function, NUMBER_OF_ACTIVATION_CYCLES,
           busy, job_done, job_error} !== '0) begin
         n_bad++; $display("FAIL arst_outputs got nonzero outputs, required all 0");
      end
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         finished_activation = 1'(i & 1);
         @(negedge clk);
      end
      finished_activation = 1'b0;
      @(negedge clk);
      n_vec++;
      if ({job_ready, busy, enable_nonlinear_block} !== 3'b100 || n_done !== 0 || n_err !== 0) begin
         n_bad++; $display("FAIL arst_idle got %b done=%0d err=%0d want 100/0/0",
                           {job_ready, busy, enable_nonlinear_block}, n_done, n_err);
      end
   endtask

   task automatic test_random_jobs();
      int acc, lb, r, len, fin_at, exp_w, rm;
      logic m, ld, ok;
      logic [TW-1:0]  ty;
      logic [31:0]    act;
      logic [TOB-1:0] lim;
      for (int j = 0; j < 25; j++) begin
         m = 1'($urandom); ty = TW'($urandom); act = $urandom; ld = 1'($urandom);
         len = $urandom_range(0, 12);
         lim = ($urandom_range(0, 3) == 0) ? '0 : TOB'($urandom_range(1, 20));
         fin_at = (lim == '0 || $urandom_range(0, 1) == 1) ? $urandom_range(0, 25) : -1;
         for (int i = 0; i < 12; i++) lut_src[i] = DW'($urandom);
         clr_mon();
         drive_job(m, ty, act, ld, len, lim, fin_at, 30, -1, acc, lb, r);
         exp_w = (ld && len != 0) ? len : 0;
         rm = (exp_w != 0) ? lb + 2 : acc + 2;
         ok = (fin_at >= 0) && (lim == '0 || fin_at < int'(lim));
         n_vec++;
         if (t_rise !== rm) begin
            n_bad++; $display("FAIL rnd%0d_start got %0d want %0d", j, t_rise, rm);
         end
         n_vec++;
         if (ok && (n_done !== 1 || n_err !== 0 || t_done !== rm + fin_at + 2)) begin
            n_bad++; $display("FAIL rnd%0d_done got n=%0d err=%0d t=%0d want 1/0/%0d",
                              j, n_done, n_err, t_done, rm + fin_at + 2);
         end else if (!ok && (n_err !== 1 || n_done !== 0 || t_err !== rm + int'(lim))) begin
            n_bad++; $display("FAIL rnd%0d_timeout got n=%0d done=%0d t=%0d want 1/0/%0d",
                              j, n_err, n_done, t_err, rm + int'(lim));
         end
         n_vec++;
         if (w_addr.size() !== exp_w) begin
            n_bad++; $display("FAIL rnd%0d_writes got %0d want %0d", j, w_addr.size(), exp_w);
         end
         for (int i = 0; i < exp_w; i++) begin
            n_vec++;
            if ({w_addr[i], w_data[i]} !== {LA'(i), lut_src[i]}) begin
               n_bad++; $display("FAIL rnd%0d_write%0d got %h/%h want %h/%h", j, i, w_addr[i],
                                 w_data[i], LA'(i), lut_src[i]);
            end
         end
         n_vec++;
         if ({seen_pool, seen_sig, both_hi != 0} !== {!m, m, 1'b0}) begin
            n_bad++; $display("FAIL rnd%0d_selects got %b want %b", j,
                              {seen_pool, seen_sig, both_hi != 0}, {!m, m, 1'b0});
         end
         n_vec++;
         if ({type_nonlinear_function, NUMBER_OF_ACTIVATION_CYCLES} !== {ty, act}) begin
            n_bad++; $display("FAIL rnd%0d_latched got %0d/%0d want %0d/%0d", j,
                              type_nonlinear_function, NUMBER_OF_ACTIVATION_CYCLES, ty, act);
         end
      end
   endtask

   initial begin
      reset = 1'b1; job_valid = 1'b0; job_mode = 1'b0; job_type_nl = '0; job_load_lut = 1'b0;
      job_lut_len = '0; job_act_cycles = '0; timeout_limit = '0; abort = 1'b0;
      lut_valid = 1'b0; lut_data = '0; finished_activation = 1'b0;
      clr_mon();
      test_reset();
      test_pooling();
      test_lut_load();
      test_timeout();
      test_race();
      test_abort();
      test_async_reset();
      test_random_jobs();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
